// File: rtl/tartaruga_pkg.sv
// -----------------------------------------------------------------------------
// tartaruga_pkg
// Shared types and constants for the tartaruga memory subsystem.
//   TLB_ENTRIES  : default number of fully-associative TLB entries (power of 2)
//   tlb_entry_t  : one TLB entry (valid, vpn, ppn)
//   tlb_state_t  : TLB miss-handling FSM states
//   make_paddr() : join a physical page number with the page offset
// -----------------------------------------------------------------------------
package tartaruga_pkg;

    localparam int TLB_ENTRIES = 8;
    localparam int VPN_W       = 20;
    localparam int PPN_W       = 20;
    localparam int OFF_W       = 12;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        RESPOND   = 2'd3
    } tlb_state_t;

    // Physical address = page number from the entry, offset from the request.
    function automatic logic [31:0] make_paddr(input logic [PPN_W-1:0] ppn,
                                               input logic [31:0]      vaddr);
        return {ppn, vaddr[OFF_W-1:0]};
    endfunction

endpackage

// File: rtl/tlb.sv
// -----------------------------------------------------------------------------
// tlb
// Fully-associative translation lookaside buffer with a single outstanding
// miss. Hits respond the cycle after acceptance (one per cycle sustained);
// misses hand the address to a page-table walker and respond the cycle after
// the walker's matching fill.
//
// Ports
//   clk_i          : clock
//   rstn_i         : synchronous active-low reset
//   req_valid_i    : translation request valid
//   req_vaddr_i    : virtual address to translate
//   req_ready_o    : high in IDLE; request accepted when valid && ready
//   resp_valid_o   : one-cycle translation result pulse
//   resp_paddr_o   : translated physical address (0 when no response)
//   flush_i        : invalidate all entries
//   tlb_miss_o     : one-cycle walk-start pulse to the walker
//   miss_vaddr_o   : address being walked, held while the miss is pending
//   ptw_busy_i     : walker busy; walk start is deferred while high
//   tlb_update_i   : walker fill valid
//   update_vpn_i   : filled virtual page number
//   update_ppn_i   : filled physical page number
// -----------------------------------------------------------------------------
module tlb
    import tartaruga_pkg::*;
#(
    parameter int ENTRIES = TLB_ENTRIES
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    input  logic [31:0]      req_vaddr_i,
    output logic             req_ready_o,
    output logic             resp_valid_o,
    output logic [31:0]      resp_paddr_o,
    input  logic             flush_i,
    output logic             tlb_miss_o,
    output logic [31:0]      miss_vaddr_o,
    input  logic             ptw_busy_i,
    input  logic             tlb_update_i,
    input  logic [VPN_W-1:0] update_vpn_i,
    input  logic [PPN_W-1:0] update_ppn_i
);

    localparam int                IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ENTRIES - 1);

    tlb_state_t         r_state;
    tlb_state_t         w_state_nxt;
    tlb_entry_t         r_entries [ENTRIES];
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [31:0]        r_miss_vaddr;
    logic [31:0]        w_miss_vaddr_nxt;
    logic               r_resp_valid;
    logic               w_resp_valid_nxt;
    logic [31:0]        r_resp_paddr;
    logic [31:0]        w_resp_paddr_nxt;
    logic               r_tlb_miss;
    logic               w_tlb_miss_nxt;

    logic [ENTRIES-1:0] w_hit_vec;
    logic               w_hit;
    logic [PPN_W-1:0]   w_hit_ppn;
    logic [ENTRIES-1:0] w_same_vec;
    logic [ENTRIES-1:0] w_free_vec;
    logic [IDX_W-1:0]   w_same_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_victim_idx;
    logic               w_use_rr;
    logic               w_fill_match;
    logic               w_install;

    assign req_ready_o  = (r_state == IDLE);
    assign resp_valid_o = r_resp_valid;
    assign resp_paddr_o = r_resp_paddr;
    assign tlb_miss_o   = r_tlb_miss;
    assign miss_vaddr_o = r_miss_vaddr;

    // Parallel lookup of the request VPN; VPNs are unique among valid
    // entries, so OR-ing the masked PPNs yields the single hit PPN.
    always_comb begin
        w_hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_hit_vec[i] = r_entries[i].valid &&
                           (r_entries[i].vpn == req_vaddr_i[31:OFF_W]);
            w_hit_ppn    = w_hit_ppn | ({PPN_W{w_hit_vec[i]}} & r_entries[i].ppn);
        end
    end

    assign w_hit = |w_hit_vec;

    // Victim candidates: entry already holding the fill VPN, and the
    // lowest-index invalid entry (descending scan so the lowest wins).
    always_comb begin
        w_same_idx = '0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_same_vec[i] = r_entries[i].valid && (r_entries[i].vpn == update_vpn_i);
            w_free_vec[i] = !r_entries[i].valid;
            w_same_idx    = w_same_vec[i] ? IDX_W'(i) : w_same_idx;
            w_free_idx    = w_free_vec[i] ? IDX_W'(i) : w_free_idx;
        end
    end

    // Victim priority: overwrite same VPN, else first free, else round-robin.
    always_comb begin
        w_use_rr = 1'b0;
        if (|w_same_vec) begin
            w_victim_idx = w_same_idx;
        end else if (|w_free_vec) begin
            w_victim_idx = w_free_idx;
        end else begin
            w_victim_idx = r_rr_ptr;
            w_use_rr     = 1'b1;
        end
    end

    assign w_fill_match = tlb_update_i && (update_vpn_i == r_miss_vaddr[31:OFF_W]);

    // FSM next state plus next values of the registered outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_resp_valid_nxt = 1'b0;
        w_resp_paddr_nxt = '0;
        w_tlb_miss_nxt   = 1'b0;
        w_miss_vaddr_nxt = r_miss_vaddr;
        w_install        = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_i && w_hit) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_paddr_nxt = make_paddr(w_hit_ppn, req_vaddr_i);
                end else if (req_valid_i) begin
                    w_miss_vaddr_nxt = req_vaddr_i;
                    w_state_nxt      = MISS_REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MISS_REQ: begin
                if (!ptw_busy_i) begin
                    w_tlb_miss_nxt = 1'b1;
                    w_state_nxt    = MISS_WAIT;
                end else begin
                    w_state_nxt = MISS_REQ;
                end
            end
            MISS_WAIT: begin
                // The response is registered here so it lands in RESPOND,
                // one cycle after the fill. A coincident flush suppresses
                // the install but not the response.
                if (w_fill_match) begin
                    w_install        = !flush_i;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_paddr_nxt = make_paddr(update_ppn_i, r_miss_vaddr);
                    w_state_nxt      = RESPOND;
                end else begin
                    w_state_nxt = MISS_WAIT;
                end
            end
            RESPOND: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered response, walk-start pulse and pending miss address.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_resp_valid <= 1'b0;
            r_resp_paddr <= '0;
            r_tlb_miss   <= 1'b0;
            r_miss_vaddr <= '0;
        end else begin
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_paddr <= w_resp_paddr_nxt;
            r_tlb_miss   <= w_tlb_miss_nxt;
            r_miss_vaddr <= w_miss_vaddr_nxt;
        end
    end

    // Entry array: flush clears every valid bit, otherwise install on fill.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (w_install) begin
            r_entries[w_victim_idx] <= '{valid: 1'b1, vpn: update_vpn_i, ppn: update_ppn_i};
        end else begin
            r_entries <= r_entries;
        end
    end

    // Round-robin pointer advances only when it actually chose the victim.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rr_ptr <= '0;
        end else if (flush_i) begin
            r_rr_ptr <= '0;
        end else if (w_install && w_use_rr) begin
            r_rr_ptr <= (r_rr_ptr == LAST_IDX) ? '0 : r_rr_ptr + IDX_W'(1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

endmodule

// File: tb/tb_tlb.sv
// -----------------------------------------------------------------------------
// tb_tlb
// Self-checking bench for tlb: directed scenarios followed by randomized
// request/fill/flush traffic, checked against a table-based reference model.
// -----------------------------------------------------------------------------
module tb_tlb;
    import tartaruga_pkg::*;

    localparam int N = TLB_ENTRIES;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic [31:0] req_vaddr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        flush;
    logic        tlb_miss;
    logic [31:0] miss_vaddr;
    logic        ptw_busy;
    logic        tlb_update;
    logic [19:0] update_vpn;
    logic [19:0] update_ppn;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain table of translations plus a replacement pointer.
    bit          m_valid [N];
    logic [19:0] m_vpn   [N];
    logic [19:0] m_ppn   [N];
    int          m_ptr;

    always #5 clk = ~clk;

    tlb #(.ENTRIES(N)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_vaddr_i  (req_vaddr),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_paddr_o (resp_paddr),
        .flush_i      (flush),
        .tlb_miss_o   (tlb_miss),
        .miss_vaddr_o (miss_vaddr),
        .ptw_busy_i   (ptw_busy),
        .tlb_update_i (tlb_update),
        .update_vpn_i (update_vpn),
        .update_ppn_i (update_ppn)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic m_lookup(input logic [19:0] vpn, output bit hit, output logic [19:0] ppn);
        hit = 1'b0;
        ppn = '0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_vpn[i] == vpn) begin
                hit = 1'b1;
                ppn = m_ppn[i];
            end
        end
    endtask

    task automatic m_install(input logic [19:0] vpn, input logic [19:0] ppn);
        int idx = -1;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_vpn[i] == vpn) idx = i;
        for (int i = 0; i < N && idx < 0; i++)
            if (!m_valid[i]) idx = i;
        if (idx < 0) begin
            idx   = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_valid[idx] = 1'b1;
        m_vpn[idx]   = vpn;
        m_ppn[idx]   = ppn;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_clear();
    endtask

    // One complete translation; on a miss the bench plays the walker.
    task automatic do_request(input logic [31:0] va, input int busy_n, input logic [19:0] ppn,
                              input bit mismatch, input bit flush_wait, input bit flush_fill,
                              output bit was_hit, output logic [31:0] pa_seen);
        logic [19:0] hppn;
        logic [19:0] mm_vpn;
        m_lookup(va[31:12], was_hit, hppn);
        check_eq("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_vaddr = va;
        tick();
        req_valid = 1'b0;
        req_vaddr = $urandom;
        pa_seen   = resp_paddr;
        if (was_hit) begin
            check_eq("hit_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("hit_paddr", resp_paddr, {hppn, va[11:0]});
            check_eq("hit_no_miss", {31'd0, tlb_miss}, 32'd0);
            check_eq("hit_ready", {31'd0, req_ready}, 32'd1);
        end else begin
            check_eq("miss_no_resp", {31'd0, resp_valid}, 32'd0);
            check_eq("miss_paddr0", resp_paddr, 32'd0);
            check_eq("miss_vaddr", miss_vaddr, va);
            check_eq("miss_not_ready", {31'd0, req_ready}, 32'd0);
            ptw_busy = 1'b1;
            for (int k = 0; k < busy_n; k++) begin
                tick();
                check_eq("busy_no_miss", {31'd0, tlb_miss}, 32'd0);
                check_eq("busy_vaddr_held", miss_vaddr, va);
            end
            ptw_busy = 1'b0;
            tick();
            check_eq("miss_pulse", {31'd0, tlb_miss}, 32'd1);
            check_eq("miss_pulse_vaddr", miss_vaddr, va);
            flush = flush_wait;
            tick();
            flush = 1'b0;
            if (flush_wait) m_clear();
            check_eq("miss_once", {31'd0, tlb_miss}, 32'd0);
            check_eq("wait_no_resp", {31'd0, resp_valid}, 32'd0);
            if (mismatch) begin
                mm_vpn     = (va[31:12] == 20'h00001) ? 20'h00002 : 20'h00001;
                tlb_update = 1'b1;
                update_vpn = mm_vpn;
                update_ppn = 20'($urandom);
                tick();
                tlb_update = 1'b0;
                check_eq("mismatch_no_resp", {31'd0, resp_valid}, 32'd0);
                check_eq("mismatch_not_ready", {31'd0, req_ready}, 32'd0);
                check_eq("mismatch_no_miss", {31'd0, tlb_miss}, 32'd0);
            end
            tlb_update = 1'b1;
            update_vpn = va[31:12];
            update_ppn = ppn;
            flush      = flush_fill;
            tick();
            tlb_update = 1'b0;
            flush      = 1'b0;
            update_vpn = 20'($urandom);
            pa_seen    = resp_paddr;
            check_eq("fill_resp_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("fill_paddr", resp_paddr, {ppn, va[11:0]});
            if (flush_fill) m_clear();
            else            m_install(va[31:12], ppn);
            tick();
            check_eq("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
            check_eq("paddr_zero_idle", resp_paddr, 32'd0);
            check_eq("ready_after_resp", {31'd0, req_ready}, 32'd1);
        end
    endtask

    // Consecutive hit requests, one per cycle; optional flush with the last.
    task automatic b2b_hits(input int n, input bit flush_last);
        int          cand [$];
        int          j;
        logic [31:0] va;
        for (int i = 0; i < N; i++) if (m_valid[i]) cand.push_back(i);
        if (cand.size() == 0) return;
        for (int k = 0; k < n; k++) begin
            j         = cand[$urandom_range(0, cand.size() - 1)];
            va        = {m_vpn[j], 12'($urandom)};
            req_valid = 1'b1;
            req_vaddr = va;
            flush     = flush_last && (k == n - 1);
            tick();
            check_eq("b2b_valid", {31'd0, resp_valid}, 32'd1);
            check_eq("b2b_paddr", resp_paddr, {m_ppn[j], va[11:0]});
            check_eq("b2b_ready", {31'd0, req_ready}, 32'd1);
        end
        if (flush_last) m_clear();
        req_valid = 1'b0;
        flush     = 1'b0;
        tick();
        check_eq("b2b_end", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        bit          hit;
        logic [31:0] pa;
        logic [19:0] vpn;

        rstn = 1'b0; req_valid = 1'b0; req_vaddr = '0; flush = 1'b0;
        ptw_busy = 1'b0; tlb_update = 1'b0; update_vpn = '0; update_ppn = '0;
        m_clear();
        tick();
        tick();
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_tlb_miss", {31'd0, tlb_miss}, 32'd0);
        check_eq("rst_miss_vaddr", miss_vaddr, 32'd0);
        check_eq("rst_paddr", resp_paddr, 32'd0);
        rstn = 1'b1;
        tick();
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);

        // First translation misses, second in the same page hits.
        do_request(32'h1234_5ABC, 0, 20'h00ABC, 1'b0, 1'b0, 1'b0, hit, pa);
        check_eq("first_is_miss", {31'd0, hit}, 32'd0);
        check_eq("first_paddr", pa, 32'h00AB_CABC);
        do_request(32'h1234_5FFF, 0, 20'h0, 1'b0, 1'b0, 1'b0, hit, pa);
        check_eq("second_is_hit", {31'd0, hit}, 32'd1);
        check_eq("second_paddr", pa, 32'h00AB_CFFF);

        // Walker busy for 5 cycles before the walk can start.
        do_request(32'h0BAD_0123, 5, 20'h11111, 1'b0, 1'b0, 1'b0, hit, pa);

        // Nine distinct pages into eight entries: the first one is evicted.
        do_flush();
        for (int i = 0; i < 9; i++)
            do_request({20'h40000 + 20'(i), 12'h010}, 0, 20'h70000 + 20'(i),
                       1'b0, 1'b0, 1'b0, hit, pa);
        for (int i = 1; i < 9; i++) begin
            do_request({20'h40000 + 20'(i), 12'h020}, 0, 20'h0, 1'b0, 1'b0, 1'b0, hit, pa);
            check_eq("evict_survivor_hit", {31'd0, hit}, 32'd1);
        end
        do_request({20'h40000, 12'h030}, 0, 20'h7AAAA, 1'b0, 1'b0, 1'b0, hit, pa);
        check_eq("evicted_first_miss", {31'd0, hit}, 32'd0);

        // Ignored mismatched fill, then a fill that coincides with a flush.
        do_request(32'h2222_2444, 1, 20'h33333, 1'b1, 1'b0, 1'b1, hit, pa);
        check_eq("flush_fill_paddr", pa, 32'h3333_3444);
        do_request(32'h2222_2555, 0, 20'h44444, 1'b0, 1'b0, 1'b0, hit, pa);
        check_eq("flush_fill_not_installed", {31'd0, hit}, 32'd0);

        // Back-to-back hits, the last coinciding with a flush.
        b2b_hits(6, 1'b1);
        do_request(32'h2222_2666, 0, 20'h55555, 1'b0, 1'b0, 1'b0, hit, pa);
        check_eq("post_flush_miss", {31'd0, hit}, 32'd0);

        // Reset while waiting for the walker, with a matching fill in that cycle.
        check_eq("rstmid_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_vaddr = 32'h6666_6777;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("rstmid_miss_pulse", {31'd0, tlb_miss}, 32'd1);
        rstn       = 1'b0;
        tlb_update = 1'b1;
        update_vpn = 20'h66666;
        update_ppn = 20'h12121;
        tick();
        rstn       = 1'b1;
        tlb_update = 1'b0;
        m_clear();
        check_eq("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
        check_eq("rstmid_vaddr0", miss_vaddr, 32'd0);
        tick();
        check_eq("rstmid_no_resp2", {31'd0, resp_valid}, 32'd0);
        check_eq("rstmid_ready_after", {31'd0, req_ready}, 32'd1);
        do_request(32'h2222_2666, 0, 20'h56565, 1'b0, 1'b0, 1'b0, hit, pa);
        check_eq("rstmid_lookup_miss", {31'd0, hit}, 32'd0);
        do_request(32'h6666_6777, 0, 20'h67676, 1'b0, 1'b0, 1'b0, hit, pa);
        check_eq("rstmid_lookup_miss2", {31'd0, hit}, 32'd0);

        // Randomized traffic over a small page pool to mix hits, misses,
        // replacement and flushes.
        for (int t = 0; t < 150; t++) begin
            int sel = $urandom_range(0, 19);
            if (sel == 0) begin
                do_flush();
            end else if (sel == 1) begin
                b2b_hits($urandom_range(1, 5), $urandom_range(0, 3) == 0);
            end else begin
                vpn = 20'h50000 + 20'($urandom_range(0, 11));
                do_request({vpn, 12'($urandom)}, $urandom_range(0, 3), 20'($urandom),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                           $urandom_range(0, 9) == 0, hit, pa);
            end
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check_eq("idle_no_resp", {31'd0, resp_valid}, 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb.md
TLB -- requirements
Module: tlb

Interface
REQ-001 Parameter ENTRIES SHALL default to 8 (TLB_ENTRIES from tartaruga_pkg); number of fully-associative entries, power of two.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  input  1  single clock.
- rstn_i  input  1  reset, synchronous, active-low.
- req_valid_i  input  1  translation request valid.
- req_vaddr_i  input  32  virtual address.
- req_ready_o  output  1  request accepted when high with req_valid_i.
- resp_valid_o  output  1  one-cycle translation result pulse.
- resp_paddr_o  output  32  physical address.
- flush_i  input  1  invalidate all entries.
- tlb_miss_o  output  1  one-cycle walk-start pulse to PTW.
- miss_vaddr_o  output  32  address to walk; held while a miss is pending.
- ptw_busy_i  input  1  PTW walking.
- tlb_update_i  input  1  PTW fill valid, one cycle.
- update_vpn_i  input  20  filled VPN.
- update_ppn_i  input  20  filled PPN.

Function
REQ-003 Entry SHALL hold valid, vpn[19:0], ppn[19:0]; lookup compares req_vaddr_i[31:12] against all valid entries in parallel.
REQ-004 FSM SHALL have states IDLE, MISS_REQ, MISS_WAIT, RESPOND; req_ready_o = (state == IDLE).
REQ-005 IDLE, accepted request, hit: resp_valid_o SHALL pulse next cycle with resp_paddr_o = {ppn, vaddr[11:0]}; state stays IDLE; back-to-back hits sustain one per cycle.
REQ-006 IDLE, accepted request, miss: SHALL latch vaddr into miss_vaddr_o, go to MISS_REQ.
REQ-007 MISS_REQ: when ptw_busy_i == 0, SHALL assert tlb_miss_o for exactly one cycle and go to MISS_WAIT; otherwise wait with tlb_miss_o low.
REQ-008 MISS_WAIT: tlb_update_i with update_vpn_i == miss_vaddr_o[31:12] SHALL install entry and go to RESPOND; non-matching updates SHALL be ignored.
REQ-009 RESPOND: SHALL pulse resp_valid_o with {update_ppn, miss_vaddr[11:0]} (PPN latched at update) and return to IDLE.
REQ-010 Miss-to-response latency SHALL be exactly 1 cycle after the tlb_update_i cycle.
REQ-011 Victim: existing valid entry with same VPN if present (overwrite), else lowest-index invalid entry, else round-robin pointer; pointer increments only on round-robin use, wraps ENTRIES-1 -> 0.
REQ-012 flush_i SHALL clear all valid bits next cycle in any state; pointer reset to 0; a pending miss SHALL still complete and respond.
REQ-013 flush_i coincident with matching tlb_update_i: flush wins, entry not installed, response still issued.
REQ-014 flush_i coincident with accepted request in IDLE: lookup uses pre-flush contents.
REQ-015 resp_paddr_o SHALL be 0 whenever resp_valid_o is low.

Reset
REQ-016 On rstn_i low at a clk_i edge: state IDLE, all valid bits 0, pointer 0, miss_vaddr_o 0; tlb_miss_o, resp_valid_o 0; req_ready_o 1 after release.
REQ-017 Reset mid-miss SHALL abandon the miss; no response issued.

Structure
REQ-018 TLB_ENTRIES, tlb_entry_t (valid, vpn, ppn) and tlb_state_t SHALL live in tartaruga_pkg.
REQ-019 No sub-module; entry array, comparators and FSM inline.

Verification
REQ-020 Reset, then request 0x1234_5ABC -> miss: tlb_miss_o 1 cycle, miss_vaddr_o 0x1234_5ABC; update vpn 0x12345 ppn 0x00ABC -> resp_paddr_o 0x00AB_CABC next cycle.
REQ-021 Repeat 0x1234_5FFF -> hit, resp_valid_o next cycle, paddr 0x00AB_CFFF, no tlb_miss_o.
REQ-022 Miss with ptw_busy_i high 5 cycles -> tlb_miss_o fires on first cycle busy is low, once only.
REQ-023 Fill 9 distinct VPNs (ENTRIES=8) -> 9th replaces entry 0; lookup of first VPN misses, VPNs 2-9 hit.
REQ-024 Mismatched update vpn 0x00001 during MISS_WAIT -> ignored, state holds; flush with matching update -> response issued, later lookup misses.
REQ-025 Reset asserted in MISS_WAIT -> no resp_valid_o, req_ready_o high after release, all lookups miss.
